// File: rtl/adc_mon_pkg.sv
// adc_mon_pkg: shared mode encodings for the ADC channel monitor
package adc_mon_pkg;
  localparam int MODE_W = 2;
  typedef enum logic [MODE_W-1:0] {
    MODE_OFF    = 2'd0,
    MODE_RAW    = 2'd1,
    MODE_CENTRE = 2'd2,
    MODE_THRESH = 2'd3
  } mode_t;
endpackage

// File: rtl/pwm_gen_param.sv
// pwm_gen_param: free-running PWM whose duty only changes at counter wrap, so no runt pulses
module pwm_gen_param #(
  parameter int PWM_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PWM_W-1:0] duty_next,
  output logic             pwm
);
  logic [PWM_W-1:0] cnt;
  logic [PWM_W-1:0] duty;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt  <= '0;
      duty <= '0;
      pwm  <= 1'b0;
    end else begin
      cnt <= cnt + 1'b1;
      if (&cnt) duty <= duty_next;
      pwm <= cnt < duty;
    end
endmodule

// File: rtl/adc_channel_monitor.sv
// adc_channel_monitor: windowed averaging of NUM_CH ADC channels driving an LED bar,
// a PWM LED and a hysteretic threshold alarm from the selected channel.
module adc_channel_monitor
  import adc_mon_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int ADC_W    = 12,
  parameter int LED_W    = 8,
  parameter int PWM_W    = 7,
  parameter int AVG_LOG2 = 2,
  parameter int HYST     = 32,
  localparam int CH_W    = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic                    CLOCK_50,
  input  logic                    RESET_N,
  input  logic [NUM_CH*ADC_W-1:0] adc_data,
  input  logic                    adc_valid,
  input  logic [MODE_W-1:0]       mode,
  input  logic [CH_W-1:0]         ch_sel,
  input  logic [ADC_W-1:0]        threshold,
  output logic [LED_W-1:0]        LED,
  output logic                    LED_PWM,
  output logic                    avg_valid,
  output logic                    alarm
);
  localparam int ACC_W = ADC_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 > 0 ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [ADC_W-1:0] MID = {1'b1, {(ADC_W-1){1'b0}}};

  logic [CNT_W-1:0]        cnt;
  logic                    last;
  logic [NUM_CH*ADC_W-1:0] avg_all;
  logic [CH_W-1:0]         sel;
  logic [ADC_W-1:0]        a;
  logic [ADC_W-1:0]        diff;
  logic [ADC_W-2:0]        dev;
  logic                    hi;
  logic                    lo;
  logic                    alarm_d;
  logic [LED_W-1:0]        led_d;
  logic [PWM_W-1:0]        duty_d;
  logic [PWM_W-1:0]        duty_next;

  assign last = cnt == LAST;

  always_ff @(posedge CLOCK_50 or negedge RESET_N)
    if (!RESET_N) begin
      cnt       <= '0;
      avg_valid <= 1'b0;
    end else begin
      avg_valid <= adc_valid && last;
      if (adc_valid) cnt <= last ? '0 : cnt + 1'b1;
    end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;
    logic [ADC_W-1:0] avg;
    assign sum = acc + ACC_W'(adc_data[c*ADC_W +: ADC_W]);
    assign avg_all[c*ADC_W +: ADC_W] = avg;
    always_ff @(posedge CLOCK_50 or negedge RESET_N)
      if (!RESET_N) begin
        acc <= '0;
        avg <= '0;
      end else if (adc_valid) begin
        acc <= last ? '0 : sum;
        if (last) avg <= ADC_W'(sum >> AVG_LOG2);
      end
  end

  // Out-of-range channel selects fall back to channel 0
  assign sel  = 32'(ch_sel) < NUM_CH ? ch_sel : '0;
  assign a    = avg_all[sel*ADC_W +: ADC_W];
  assign diff = a >= MID ? a - MID : MID - a;
  assign dev  = diff[ADC_W-1] ? '1 : diff[ADC_W-2:0];

  // Widened compare so avg + HYST cannot wrap
  assign hi      = a >= threshold;
  assign lo      = {1'b0, a} + (ADC_W+1)'(HYST) < {1'b0, threshold};
  assign alarm_d = (mode == MODE_THRESH) && (hi ? 1'b1 : lo ? 1'b0 : alarm);
  assign led_d   = mode == MODE_RAW    ? LED_W'(a >> (ADC_W - LED_W)) :
                   mode == MODE_CENTRE ? LED_W'(dev >> (ADC_W - 1 - LED_W)) :
                   {LED_W{alarm_d}};
  assign duty_d  = mode == MODE_RAW    ? PWM_W'(a >> (ADC_W - PWM_W)) :
                   mode == MODE_CENTRE ? PWM_W'(dev >> (ADC_W - 1 - PWM_W)) :
                   {PWM_W{alarm_d}};

  // OFF forces the display dark immediately; other modes refresh only on new averages
  always_ff @(posedge CLOCK_50 or negedge RESET_N)
    if (!RESET_N) begin
      LED       <= '0;
      alarm     <= 1'b0;
      duty_next <= '0;
    end else if (mode == MODE_OFF || avg_valid) begin
      LED       <= led_d;
      alarm     <= alarm_d;
      duty_next <= duty_d;
    end

  pwm_gen_param #(.PWM_W(PWM_W)) u_pwm (
    .clk      (CLOCK_50),
    .rst_n    (RESET_N),
    .duty_next(duty_next),
    .pwm      (LED_PWM)
  );
endmodule

// File: tb/tb_adc_channel_monitor.sv
// tb_adc_channel_monitor: directed and randomized checks of the ADC monitor against a behavioural model
module tb_adc_channel_monitor;
  import adc_mon_pkg::*;
  localparam int NC  = 3;
  localparam int AW  = 12;
  localparam int WIN = 4;
  localparam int HY  = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NC*AW-1:0] adc_data = '0;
  logic          adc_valid = 1'b0;
  logic [1:0]    mode = MODE_RAW;
  logic [1:0]    ch_sel = 2'd0;
  logic [AW-1:0] threshold = '0;
  logic [7:0]    led;
  logic          led_pwm;
  logic          avg_valid;
  logic          alarm;

  int  tests = 0;
  int  fails = 0;
  bit  chk_en = 1'b0;

  always #10 clk = ~clk;

  adc_channel_monitor #(.NUM_CH(NC), .ADC_W(AW), .LED_W(8), .PWM_W(7), .AVG_LOG2(2), .HYST(HY)) dut (
    .CLOCK_50 (clk),
    .RESET_N  (rst_n),
    .adc_data (adc_data),
    .adc_valid(adc_valid),
    .mode     (mode),
    .ch_sel   (ch_sel),
    .threshold(threshold),
    .LED      (led),
    .LED_PWM  (led_pwm),
    .avg_valid(avg_valid),
    .alarm    (alarm)
  );

  task automatic check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: window sums divided by window size, display rules as arithmetic,
  // PWM as a phase within a 128-clock period with duty adopted at each period start.
  int m_avg[NC];
  int m_sum[NC];
  int m_n, m_led, m_dnext, m_duty, m_phase, m_a, m_dev, m_sel;
  bit m_av, m_alarm, m_pwm;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NC; c++) begin
        m_avg[c] = 0;
        m_sum[c] = 0;
      end
      m_n = 0; m_led = 0; m_dnext = 0; m_duty = 0; m_phase = 0;
      m_av = 0; m_alarm = 0; m_pwm = 0;
    end else begin
      m_pwm = m_phase < m_duty;
      if (m_phase == 127) m_duty = m_dnext;
      m_phase = (m_phase + 1) % 128;
      if (mode == MODE_OFF) begin
        m_led = 0; m_dnext = 0; m_alarm = 0;
      end else if (m_av) begin
        m_sel = ch_sel < NC ? int'(ch_sel) : 0;
        m_a = m_avg[m_sel];
        if (mode == MODE_THRESH) begin
          if (m_a >= int'(threshold)) m_alarm = 1;
          else if (m_a + HY < int'(threshold)) m_alarm = 0;
          m_led   = m_alarm ? 255 : 0;
          m_dnext = m_alarm ? 127 : 0;
        end else begin
          m_alarm = 0;
          m_dev = m_a < 2048 ? 2048 - m_a : m_a - 2048;
          if (m_dev > 2047) m_dev = 2047;
          m_led   = mode == MODE_RAW ? m_a / 16 : m_dev / 8;
          m_dnext = mode == MODE_RAW ? m_a / 32 : m_dev / 16;
        end
      end
      m_av = 0;
      if (adc_valid) begin
        for (int c = 0; c < NC; c++) m_sum[c] += int'(adc_data[c*AW +: AW]);
        m_n++;
        if (m_n == WIN) begin
          for (int c = 0; c < NC; c++) begin
            m_avg[c] = m_sum[c] / WIN;
            m_sum[c] = 0;
          end
          m_n = 0;
          m_av = 1;
        end
      end
    end
  end

  always @(negedge clk)
    if (rst_n && chk_en) begin
      check("avg_valid", avg_valid, m_av);
      check("LED", led, m_led);
      check("alarm", alarm, m_alarm);
      check("LED_PWM", led_pwm, m_pwm);
    end

  task automatic send(int c0, int c1, int c2);
    @(negedge clk);
    adc_data  = {AW'(c2), AW'(c1), AW'(c0)};
    adc_valid = 1'b1;
    @(negedge clk);
    adc_valid = 1'b0;
  endtask

  task automatic window(int c0, int c1, int c2);
    repeat (WIN) send(c0, c1, c2);
  endtask

  task automatic pwm_high(string name, int exp);
    int hi = 0;
    repeat (140) @(negedge clk);
    repeat (128) begin
      @(negedge clk);
      hi += int'(led_pwm);
    end
    check(name, hi, exp);
  endtask

  initial begin
    int v;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset LED", led, 0);
    check("reset LED_PWM", led_pwm, 0);
    check("reset avg_valid", avg_valid, 0);
    check("reset alarm", alarm, 0);

    // RAW
    send('h800, 0, 0); send('h800, 0, 0); send('h7FC, 0, 0); send('h804, 0, 0);
    check("raw avg_valid latency", avg_valid, 1);
    @(negedge clk);
    check("raw LED", led, 'h80);
    pwm_high("raw pwm high count", 64);

    // Reset mid-window clears everything asynchronously and discards the partial window
    send('h400, 0, 0); send('h400, 0, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async LED", led, 0);
    check("async LED_PWM", led_pwm, 0);
    check("async avg_valid", avg_valid, 0);
    check("async alarm", alarm, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) send('h400, 0, 0);
    repeat (3) @(negedge clk);
    check("post-reset no early avg", avg_valid, 0);
    send('h400, 0, 0);
    check("post-reset avg_valid", avg_valid, 1);
    @(negedge clk);
    check("post-reset LED", led, 'h40);

    // CENTRE
    mode = MODE_CENTRE; ch_sel = 2'd1;
    window('h123, 0, 5);
    @(negedge clk);
    check("centre LED zero input", led, 'hFF);
    pwm_high("centre pwm full", 127);
    window('h300, 'h800, 0);
    @(negedge clk);
    check("centre LED mid input", led, 0);
    pwm_high("centre pwm none", 0);

    // THRESH with hysteresis
    mode = MODE_THRESH; ch_sel = 2'd0; threshold = 'h600;
    window('h600, 0, 0);
    @(negedge clk);
    check("thresh set alarm", alarm, 1);
    check("thresh set LED", led, 'hFF);
    window('h5F0, 0, 0);
    @(negedge clk);
    check("thresh hold alarm", alarm, 1);
    window('h5DF, 0, 0);
    @(negedge clk);
    check("thresh clear alarm", alarm, 0);
    check("thresh clear LED", led, 0);

    // OFF and out-of-range channel select
    mode = MODE_RAW;
    window('h800, 0, 0);
    @(negedge clk);
    mode = MODE_OFF;
    @(negedge clk);
    check("off LED", led, 0);
    repeat (200) @(negedge clk);
    check("off LED_PWM", led_pwm, 0);
    ch_sel = 2'd3; mode = MODE_RAW;
    window('h400, 'hC00, 'hA00);
    @(negedge clk);
    check("ch_sel clamp LED", led, 'h40);

    // Randomized: mode/channel/duty changes land mid PWM period, adc_valid bursts
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 59) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 59) == 0) ch_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) threshold = AW'($urandom_range(64, 4000));
      adc_valid = $urandom_range(0, 2) == 0;
      for (int c = 0; c < NC; c++) begin
        v = $urandom_range(0, 1) ? int'(threshold) + int'($urandom_range(0, 90)) - 60
                                 : int'($urandom_range(0, 4095));
        v = v < 0 ? 0 : v > 4095 ? 4095 : v;
        adc_data[c*AW +: AW] = AW'(v);
      end
      if (i == 2000) begin
        #3 rst_n = 1'b0;
        #4 rst_n = 1'b1;
      end
    end
    @(negedge clk);
    adc_valid = 1'b0;
    repeat (20) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
